apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_pkg.sv | 28 ++
 rtl/apb_rr_arbiter.sv | 47 ++++
 rtl/apb_req_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB request arbiter.
//   apb_state_e : APB requester phase (idle, setup, access)
//   ADDR_W/DATA_W/STRB_W/PROT_W : APB field widths
//   WAIT_W      : width of the ACCESS wait counter (timeouts up to 255 cycles)
//   idx_width() : width of a requester index for a given requester count
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

    // Index width never drops below one bit so single-requester builds still elaborate.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// apb_rr_arbiter
// Purely combinational round-robin picker. The search starts at the requester
// after the most recent winner and wraps, so the last winner has the lowest
// priority on the next decision.
// Ports:
//   req_i   [NumReq]  request vector
//   last_i  [IdxW]    index of the previous winner
//   gnt_o   [NumReq]  one-hot grant (all zero when nothing requests)
//   idx_o   [IdxW]    binary index of the grant
//   valid_o           at least one requester won
// ----------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    int unsigned cand;
    logic        found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        cand    = 0;
        // Offsets 1..NumReq visit every requester once, the previous winner last.
        for (int unsigned off = 1; off <= NumReq; off++) begin
            cand = (int'(last_i) + off) % NumReq;
            if (!found && req_i[IdxW'(cand)]) begin
                found              = 1'b1;
                gnt_o[IdxW'(cand)] = 1'b1;
                idx_o              = IdxW'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// apb_req_arbiter
// Shares one APB requester port between NUM_REQ local requesters. Requests are
// granted round-robin, forwarded as a standard SETUP/ACCESS transfer, and the
// completion is returned as a one-cycle pulse to the owning requester. An
// ACCESS phase that waits TIMEOUT_CYCLES cycles without pready is aborted and
// reported as an error with rsp_timeout_o set.
// Ports:
//   pclk_i, preset_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o     per-requester handshake (ready only for winner)
//   req_write_i                 per-requester direction, 1 = write
//   req_addr_i/req_wdata_i      packed per-requester address / write data
//   req_strb_i/req_prot_i       packed per-requester strobes / protection
//   rsp_valid_o                 per-requester completion pulse
//   rsp_rdata_o                 read data (zero for writes and timeouts)
//   rsp_slverr_o/rsp_timeout_o  error flag / error caused by timeout
//   psel_o .. pprot_o           registered APB requester outputs
//   pready_i/pslverr_i/prdata_i APB completer response
// ----------------------------------------------------------------------------
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        pclk_i,
    input  logic                        preset_i,

    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ-1:0]          req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_REQ*STRB_W-1:0]   req_strb_i,
    input  logic [NUM_REQ*PROT_W-1:0]   req_prot_i,

    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_slverr_o,
    output logic                        rsp_timeout_o,

    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [ADDR_W-1:0]           paddr_o,
    output logic [DATA_W-1:0]           pwdata_o,
    output logic [STRB_W-1:0]           pstrb_o,
    output logic [PROT_W-1:0]           pprot_o,
    input  logic                        pready_i,
    input  logic                        pslverr_i,
    input  logic [DATA_W-1:0]           prdata_i
);

    localparam int unsigned       IdxW     = idx_width(NUM_REQ);
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0]   LastInit = IdxW'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    apb_state_e          state_q;
    logic [IdxW-1:0]     last_grant_q;  // also the owner of the in-flight transfer
    logic [WAIT_W-1:0]   wait_q;

    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [PROT_W-1:0]   pprot_q;

    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_slverr_q;
    logic                rsp_timeout_q;

    // ------------------------------------------------------------------------
    // Unpack per-requester fields
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [STRB_W-1:0] strb_arr  [NUM_REQ];
    logic [PROT_W-1:0] prot_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
        assign strb_arr[g]  = req_strb_i[g*STRB_W +: STRB_W];
        assign prot_arr[g]  = req_prot_i[g*PROT_W +: PROT_W];
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] gnt;
    logic [IdxW-1:0]    win_idx;
    logic               win_valid;
    logic               arb_en;
    logic               accept;
    logic [NUM_REQ-1:0] owner_onehot;

    apb_rr_arbiter #(
        .NumReq (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .last_i  (last_grant_q),
        .gnt_o   (gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // A new transfer may start when idle, or in the ACCESS cycle that completes
    // normally. A timing-out ACCESS cycle has pready low, so it never arbitrates.
    assign arb_en      = (state_q == StIdle) || ((state_q == StAccess) && pready_i);
    assign req_ready_o = arb_en ? gnt : '0;
    assign accept      = arb_en && win_valid;

    always_comb begin
        owner_onehot               = '0;
        owner_onehot[last_grant_q] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // FSM with registered APB and response outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state_q       <= StIdle;
            last_grant_q  <= LastInit;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // Response fields are single-cycle; they read as zero between pulses.
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;

            if (accept) begin
                last_grant_q <= win_idx;
                pwrite_q     <= req_write_i[win_idx];
                paddr_q      <= addr_arr[win_idx];
                pwdata_q     <= wdata_arr[win_idx];
                pstrb_q      <= strb_arr[win_idx];
                pprot_q      <= prot_arr[win_idx];
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StSetup;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end

                StSetup: begin
                    state_q   <= StAccess;
                    penable_q <= 1'b1;
                end

                StAccess: begin
                    if (pready_i) begin
                        rsp_valid_q  <= owner_onehot;
                        rsp_rdata_q  <= pwrite_q ? '0 : prdata_i;
                        rsp_slverr_q <= pslverr_i;
                        wait_q       <= '0;
                        // Back-to-back: a same-cycle grant goes straight to SETUP.
                        state_q      <= accept ? StSetup : StIdle;
                        psel_q       <= accept;
                        penable_q    <= 1'b0;
                    end else if (wait_q == WaitLast) begin
                        rsp_valid_q   <= owner_onehot;
                        rsp_slverr_q  <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        wait_q        <= '0;
                        state_q       <= StIdle;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                default: begin
                    state_q   <= StIdle;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    wait_q    <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign pprot_o       = pprot_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_slverr_o  = rsp_slverr_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter. Requester transactions are queued per
// port; on each accept the expected completion is pushed to a scoreboard that
// a separate monitor drains whenever rsp_valid is seen. A small completer model
// answers ACCESS phases after a configurable number of wait cycles.
// ----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned TO = 16;

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_write;
    logic [NR*32-1:0]  req_addr;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*4-1:0]   req_strb;
    logic [NR*3-1:0]   req_prot;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;
    logic              pready;
    logic              pslverr;
    logic [31:0]       prdata;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } txn_t;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    txn_t        pend [NR][$];
    exp_t        sb [$];
    int          gnt_q [$];
    int          idle_cnt;
    int          first_acc;
    int          last_acc;
    int          acc;

    // Completer model configuration.
    int          cfg_wait;
    logic [31:0] cfg_rdata;
    logic        cfg_slverr;

    apb_req_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk_i        (pclk),
        .preset_i      (preset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_prot_i    (req_prot),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_slverr_o  (rsp_slverr),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .pprot_o       (pprot),
        .pready_i      (pready),
        .pslverr_i     (pslverr),
        .prdata_i      (prdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return {18'd0, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
                rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout};
    endfunction

    function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [2:0] p);
        txn_t t;
        t.write = w;
        t.addr  = a;
        t.wdata = d;
        t.strb  = s;
        t.prot  = p;
        return t;
    endfunction

    function automatic int pending_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += pend[i].size();
        return n;
    endfunction

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            if (pend[i].size() != 0) begin
                req_valid[i]         = 1'b1;
                req_write[i]         = pend[i][0].write;
                req_addr[i*32 +: 32] = pend[i][0].addr;
                req_wdata[i*32 +: 32] = pend[i][0].wdata;
                req_strb[i*4 +: 4]   = pend[i][0].strb;
                req_prot[i*3 +: 3]   = pend[i][0].prot;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the last accept.
    task automatic drive_all(input int budget);
        int   n = 0;
        bit   granted = 1'b0;
        exp_t e;
        txn_t t;
        gnt_q.delete();
        idle_cnt = 0;
        apply();
        while (pending_cnt() != 0 && n < budget) begin
            @(negedge pclk);
            chk("ready_onehot0", {127'd0, $onehot0(req_ready)}, 128'd1);
            if (granted && !psel) idle_cnt++;
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    chk("ready_needs_valid", {127'd0, req_valid[i]}, 128'd1);
                    if (pend[i].size() != 0) begin
                        t = pend[i].pop_front();
                        e.owner = i;
                        if (cfg_wait >= int'(TO)) begin
                            e.rdata   = 32'h0;
                            e.slverr  = 1'b1;
                            e.timeout = 1'b1;
                        end else begin
                            e.rdata   = t.write ? 32'h0 : cfg_rdata;
                            e.slverr  = cfg_slverr;
                            e.timeout = 1'b0;
                        end
                        sb.push_back(e);
                        gnt_q.push_back(i);
                        if (!granted) first_acc = cyc;
                        last_acc = cyc;
                        granted  = 1'b1;
                    end
                end
            end
            @(posedge pclk);
            #1;
            apply();
            n++;
        end
        chk("accept_within_budget", pending_cnt(), 0);
        for (int i = 0; i < NR; i++) pend[i].delete();
        apply();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        repeat (3) @(negedge pclk);
        @(posedge pclk);
        #1;
    endtask

    initial begin
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_strb   = '0;
        req_prot   = '0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        prdata     = '0;
        cfg_wait   = 0;
        cfg_rdata  = '0;
        cfg_slverr = 1'b0;

        fork
            begin : cycle_count
                forever begin
                    @(posedge pclk);
                    cyc++;
                end
            end
            begin : completer
                int acc_cnt = 0;
                forever begin
                    @(posedge pclk);
                    #1;
                    if (psel && penable) begin
                        pready  = (acc_cnt == cfg_wait);
                        pslverr = pready ? cfg_slverr : 1'b0;
                        prdata  = cfg_rdata;
                        acc_cnt++;
                    end else begin
                        pready  = 1'b0;
                        pslverr = 1'b0;
                        acc_cnt = 0;
                    end
                end
            end
            begin : monitor
                exp_t          e;
                logic [NR-1:0] exp_v;
                forever begin
                    @(negedge pclk);
                    if (!preset && rsp_valid != '0) begin
                        if (sb.size() == 0) begin
                            chk("rsp_unexpected", rsp_valid, 128'd0);
                        end else begin
                            e     = sb.pop_front();
                            exp_v = NR'(1) << e.owner;
                            chk("rsp_owner", rsp_valid, exp_v);
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_slverr", rsp_slverr, e.slverr);
                            chk("rsp_timeout", rsp_timeout, e.timeout);
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog simulation did not finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset values
        @(negedge pclk);
        chk("reset_outputs", out_vec(), 128'd0);
        @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk);
        #1;

        // Single read from req0, no waits: psel N+1, penable N+2, response N+3
        cfg_wait  = 0;
        cfg_rdata = 32'h10;
        pend[0].push_back(mk(1'b0, 32'h10, 32'h0, 4'hF, 3'd0));
        drive_all(20);
        @(negedge pclk);
        chk("t035_setup", {psel, penable, paddr}, {2'b10, 32'h10});
        @(negedge pclk);
        chk("t035_access", {psel, penable}, 2'b11);
        @(negedge pclk);
        chk("t035_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, psel},
            {2'b01, 32'h10, 1'b0, 1'b0, 1'b0});
        wait_drain("t035");

        // Timeout on req1: 16 ACCESS cycles, then abort with slverr+timeout
        cfg_wait  = 1000;
        cfg_rdata = 32'h5555_AAAA;
        pend[1].push_back(mk(1'b0, 32'h40, 32'h0, 4'hF, 3'd1));
        drive_all(20);
        @(negedge pclk);
        chk("t038_setup", {psel, penable, paddr}, {2'b10, 32'h40});
        acc = 0;
        while (acc < 40) begin
            @(negedge pclk);
            if (!penable) break;
            acc++;
        end
        chk("t038_access_cycles", acc, TO);
        chk("t038_abort", {psel, penable, rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata},
            {2'b00, 2'b10, 1'b1, 1'b1, 32'h0});
        wait_drain("t038");

        // Write from req1 with 3 wait states: fields stable over 4 ACCESS cycles
        cfg_wait  = 3;
        cfg_rdata = 32'h7777_0000;
        pend[1].push_back(mk(1'b1, 32'h84, 32'hCAFE_0084, 4'h3, 3'd2));
        drive_all(20);
        @(negedge pclk);
        chk("t037_setup", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot},
            {3'b101, 32'h84, 32'hCAFE_0084, 4'h3, 3'd2});
        acc = 0;
        while (acc < 40) begin
            @(negedge pclk);
            if (!penable) break;
            acc++;
            chk("t037_fields_stable", {psel, pwrite, paddr, pwdata, pstrb, pprot},
                {2'b11, 32'h84, 32'hCAFE_0084, 4'h3, 3'd2});
        end
        chk("t037_access_cycles", acc, 4);
        chk("t037_rsp_owner", rsp_valid, 2'b10);
        wait_drain("t037");

        // Both requesters stream 4 writes each: strict alternation, no idle gap
        cfg_wait  = 0;
        cfg_rdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            pend[0].push_back(mk(1'b1, 32'h200 + 32'(k * 4), 32'hA000_0000 + 32'(k), 4'hF, 3'd0));
            pend[1].push_back(mk(1'b1, 32'h300 + 32'(k * 4), 32'hB000_0000 + 32'(k), 4'hF, 3'd1));
        end
        drive_all(60);
        chk("t036_grant_count", gnt_q.size(), 8);
        for (int k = 0; k < gnt_q.size(); k++) begin
            chk($sformatf("t036_grant_%0d", k), gnt_q[k], k % 2);
        end
        chk("t036_no_idle", idle_cnt, 0);
        chk("t036_accept_span", last_acc - first_acc, 14);
        wait_drain("t036");

        // Completer error on read from req0
        cfg_wait   = 0;
        cfg_rdata  = 32'hBAD0_0002;
        cfg_slverr = 1'b1;
        pend[0].push_back(mk(1'b0, 32'h02, 32'h0, 4'hF, 3'd0));
        drive_all(20);
        repeat (3) @(negedge pclk);
        chk("t039_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, {2'b01, 1'b1, 1'b0});
        wait_drain("t039");
        cfg_slverr = 1'b0;

        // Reset during ACCESS aborts silently; req0 wins first afterwards
        cfg_wait = 1000;
        pend[0].push_back(mk(1'b0, 32'h100, 32'h0, 4'hF, 3'd0));
        drive_all(20);
        @(negedge pclk);
        @(negedge pclk);
        chk("t040_in_access", {psel, penable}, 2'b11);
        #2;
        preset = 1'b1;
        #1;
        chk("t040_async_reset", out_vec(), 128'd0);
        sb.delete();
        @(negedge pclk);
        @(negedge pclk);
        chk("t040_reset_hold", out_vec(), 128'd0);
        preset = 1'b0;
        @(posedge pclk);
        #1;
        cfg_wait  = 0;
        cfg_rdata = 32'h0000_4040;
        pend[0].push_back(mk(1'b0, 32'h104, 32'h0, 4'hF, 3'd0));
        pend[1].push_back(mk(1'b0, 32'h204, 32'h0, 4'hF, 3'd0));
        drive_all(30);
        chk("t040_grant_count", gnt_q.size(), 2);
        for (int k = 0; k < gnt_q.size(); k++) begin
            chk($sformatf("t040_grant_%0d", k), gnt_q[k], k);
        end
        wait_drain("t040");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
